// File: rtl/logic_unit_pkg.sv
// Shared encodings for the bitwise logic unit: operation codes and FSM states.
package logic_unit_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise function f(op, a, b).
// Ports:
//   op   : operation code (AND/OR/XOR/NOR, see logic_unit_pkg)
//   a, b : operand slices
//   y_c  : combinational result slice
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int unsigned SLICE = 8
)
(
    input  logic [OP_W-1:0]  op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y_c
);

    always_comb begin
        y_c = '0;
        case (op)
            OP_AND:  y_c = a & b;
            OP_OR:   y_c = a | b;
            OP_XOR:  y_c = a ^ b;
            OP_NOR:  y_c = ~(a | b);
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates WIDTH-bit A op B one SLICE per cycle
// (LSB slice first) behind valid/ready handshakes, then presents Y and a zero flag.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds the parity output (^Y in DONE).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B, op             : operands and operation code
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   Y, zero              : result and Y==0 flag (zero valid in DONE only)
//   parity               : XOR-reduce of Y in DONE (LOGIC_UNIT_PARITY_EN only)
module bitwise_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  y_d;
    logic              in_ready_d;
    logic              out_valid_d;
    logic              zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
    logic              parity_d;
`endif

    logic [SLICE-1:0]  a_slice_c;
    logic [SLICE-1:0]  b_slice_c;
    logic [SLICE-1:0]  y_slice_c;

    // Single slice evaluator, fed by the slice selected by the current index.
    assign a_slice_c = a_q[32'(idx_q) * SLICE +: SLICE];
    assign b_slice_c = b_q[32'(idx_q) * SLICE +: SLICE];

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op  (op_q),
        .a   (a_slice_c),
        .b   (b_slice_c),
        .y_c (y_slice_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        y_d         = Y;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        zero_d      = 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
        parity_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                y_d[32'(idx_q) * SLICE +: SLICE] = y_slice_c;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags follow the next state so they are registered alongside it;
        // Y is frozen throughout DONE, so zero/parity stay stable there.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        zero_d      = out_valid_d && (y_d == '0);
`ifdef LOGIC_UNIT_PARITY_EN
        parity_d    = out_valid_d && (^y_d);
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            Y         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            zero      <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            Y         <= y_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            zero      <= zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
            parity    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench: three units (SLICE=8, 32, 1) share the input side; each
// result is compared against a full-width reference model, including latency.
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] A, B;
    logic [1:0]  op;

    logic        in_ready8, out_valid8, zero8;
    logic        in_ready32, out_valid32, zero32;
    logic        in_ready1, out_valid1, zero1;
    logic [31:0] y8, y32, y1;
`ifdef LOGIC_UNIT_PARITY_EN
    logic        parity8, parity32, parity1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .A(A), .B(B), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
        .Y(y8), .zero(zero8)
`ifdef LOGIC_UNIT_PARITY_EN
        , .parity(parity8)
`endif
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .A(A), .B(B), .op(op), .out_valid(out_valid32), .out_ready(out_ready),
        .Y(y32), .zero(zero32)
`ifdef LOGIC_UNIT_PARITY_EN
        , .parity(parity32)
`endif
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .Y(y1), .zero(zero1)
`ifdef LOGIC_UNIT_PARITY_EN
        , .parity(parity1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic wait_all_idle();
        int c;
        c = 0;
        while (!(in_ready8 && in_ready32 && in_ready1) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issue one op to all three units and check each result and its latency.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        bit d8, d32, d1;
        exp = ref_fn(o, a, b);
        d8 = 0; d32 = 0; d1 = 0;
        wait_all_idle();
        A = a; B = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        // Post-acceptance input churn must not affect the result.
        in_valid = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
        for (int c = 1; c <= 40 && !(d8 && d32 && d1); c++) begin
            @(negedge clk);
            if (!d8 && out_valid8) begin
                d8 = 1;
                check("lat8", 32'(c), 32'd4);
                check("y8", y8, exp);
                check("zero8", 32'(zero8), 32'(exp == 0));
`ifdef LOGIC_UNIT_PARITY_EN
                check("parity8", 32'(parity8), 32'(^exp));
`endif
            end
            if (!d32 && out_valid32) begin
                d32 = 1;
                check("lat32", 32'(c), 32'd1);
                check("y32", y32, exp);
                check("zero32", 32'(zero32), 32'(exp == 0));
            end
            if (!d1 && out_valid1) begin
                d1 = 1;
                check("lat1", 32'(c), 32'd32);
                check("y1", y1, exp);
                check("zero1", 32'(zero1), 32'(exp == 0));
            end
        end
        if (!d8)  check("timeout8",  32'd0, 32'd1);
        if (!d32) check("timeout32", 32'd0, 32'd1);
        if (!d1)  check("timeout1",  32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] held_y;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        bit          seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
        repeat (2) @(negedge clk);
        check("rst_y",  y8, 32'd0);
        check("rst_ov", 32'(out_valid8), 32'd0);
        check("rst_z",  32'(zero8), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'({in_ready8, in_ready32, in_ready1}), 32'd7);

        // Directed ops.
        run_op(2'd0, 32'hFFFF0000, 32'h0F0F0F0F);
        run_op(2'd0, 32'hF0F0F0F0, 32'hFF00FF00);
        run_op(2'd1, 32'hF0F0F0F0, 32'hFF00FF00);
        run_op(2'd2, 32'hF0F0F0F0, 32'hFF00FF00);
        run_op(2'd3, 32'hF0F0F0F0, 32'hFF00FF00);
        run_op(2'd2, 32'h12345678, 32'h12345678);
        run_op(2'd1, 32'h00000001, 32'h00000002);
        run_op(2'd1, 32'h00000007, 32'h00000000);

        // Backpressure on the SLICE=8 unit.
        wait_all_idle();
        A = 32'hA5A5_1234; B = 32'h0FF0_FFFF; op = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid8;
        end
        check("bp_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("bp_y", y8, 32'hAFF5_FFFF);
            check("bp_z", 32'(zero8), 32'd0);
            check("bp_rdy", 32'(in_ready8), 32'd0);
            check("bp_ov", 32'(out_valid8), 32'd1);
            in_valid = (c == 2);
            A = 32'h0; B = 32'h0; op = 2'd0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_rdy", 32'(in_ready8), 32'd1);
        check("bp_idle_ov", 32'(out_valid8), 32'd0);
        check("bp_idle_y", y8, 32'hAFF5_FFFF);
        check("bp_idle_z", 32'(zero8), 32'd0);

        // Reset while the SLICE=8 unit is on slice index 2.
        wait_all_idle();
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; op = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_y",   y8, 32'd0);
        check("mid_rst_ov",  32'(out_valid8), 32'd0);
        check("mid_rst_rdy", 32'(in_ready8), 32'd1);
        run_op(2'd0, 32'h0000_00FF, 32'h0000_0F0F);

        // Random ops, with some forced zero results.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 3));
            if (i % 5 == 0) begin
                rb = ra;
                ro = 2'd2;
            end
            run_op(ro, ra, rb);
        end

        wait_all_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
